// File: rtl/lsu_stage_if.sv
// Purpose: groups the EXU->LSU, LSU<->data-bus and LSU->WBU signals of the load/store stage.
// Ports:   slave  = the LSU's view (takes EXU instructions, drives the bus request and WBU result);
//          master = the surrounding pipeline / bus / testbench view (mirror image of slave).
interface lsu_stage_if;
    // EXU -> LSU
    logic        exu_valid;
    logic        lsu_ready;
    logic [31:0] exu_res;
    logic [31:0] exu_wdata;
    logic        exu_memrd;
    logic        exu_memwr;
    logic [2:0]  exu_funct3;
    logic        exu_memtoreg;
    logic        exu_regw;
    // LSU <-> data bus
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    // LSU -> WBU
    logic        lsu_valid;
    logic        wbu_ready;
    logic [31:0] res;
    logic [31:0] dataout;
    logic        memtoreg;
    logic        regw;
    logic        lsu_err;

    modport slave (
        input  exu_valid, exu_res, exu_wdata, exu_memrd, exu_memwr, exu_funct3,
               exu_memtoreg, exu_regw, mem_gnt, mem_rvalid, mem_rdata, wbu_ready,
        output lsu_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
               lsu_valid, res, dataout, memtoreg, regw, lsu_err
    );

    modport master (
        output exu_valid, exu_res, exu_wdata, exu_memrd, exu_memwr, exu_funct3,
               exu_memtoreg, exu_regw, mem_gnt, mem_rvalid, mem_rdata, wbu_ready,
        input  lsu_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
               lsu_valid, res, dataout, memtoreg, regw, lsu_err
    );
endinterface

// File: rtl/lsu_stage.sv
// Purpose: load/store stage between EXU and WBU; one sized, aligned bus access per memory instruction.
// Latency: non-memory / faulting op -> lsu_valid 1 cycle after accept; memory op -> 1 cycle after mem_rvalid.
// Backpressure: lsu_ready only in IDLE; result held stable in DONE until wbu_ready.
// Ports: clk, rst (async, active-high), bus (lsu_stage_if.slave: EXU handshake, data bus, WBU handshake).
// TIMEOUT: bus cycles (REQ+WAIT) before an access aborts with lsu_err; 0 disables, max 255.
module lsu_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    lsu_stage_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state, state_d;

    logic [31:0] res_q, dout_q, addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        we_q, m2r_q, regw_q, err_q, memrd_q;
    logic [2:0]  f3_q;
    logic [7:0]  wd_cnt;
    logic        wd_hit;

    // Decode of the instruction offered by EXU
    logic        is_mem, legal, misal, acc_err;
    logic [3:0]  wstrb_d;
    logic [31:0] wdata_d;

    assign is_mem  = bus.exu_memrd | bus.exu_memwr;
    assign misal   = ((bus.exu_funct3[1:0] == 2'b01) && bus.exu_res[0]) ||
                     ((bus.exu_funct3[1:0] == 2'b10) && (bus.exu_res[1:0] != 2'b00));
    assign acc_err = is_mem & (~legal | misal);

    always_comb begin
        legal = 1'b0;
        if (bus.exu_memrd)
            legal = bus.exu_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else if (bus.exu_memwr)
            legal = bus.exu_funct3 inside {3'b000, 3'b001, 3'b010};
    end

    // Store lanes: data replicated across the word so the strobes pick the right copy
    always_comb begin
        wstrb_d = 4'b0000;
        wdata_d = bus.exu_wdata;
        if (bus.exu_memwr) begin
            case (bus.exu_funct3[1:0])
                2'b00: begin
                    wstrb_d = 4'b0001 << bus.exu_res[1:0];
                    wdata_d = {4{bus.exu_wdata[7:0]}};
                end
                2'b01: begin
                    wstrb_d = 4'b0011 << bus.exu_res[1:0];
                    wdata_d = {2{bus.exu_wdata[15:0]}};
                end
                default: wstrb_d = 4'b1111;
            endcase
        end
    end

    // Load lane extraction and extension
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_ext;

    assign ld_b = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign ld_h = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        ld_ext = 32'd0;
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_b[7]}}, ld_b};
            3'b001:  ld_ext = {{16{ld_h[15]}}, ld_h};
            3'b010:  ld_ext = bus.mem_rdata;
            3'b100:  ld_ext = {24'd0, ld_b};
            3'b101:  ld_ext = {16'd0, ld_h};
            default: ld_ext = 32'd0;
        endcase
    end

    // Watchdog fires on the last allowed bus cycle so the abort edge is cycle TIMEOUT
    assign wd_hit = (TIMEOUT != 0) && ({24'd0, wd_cnt} == (TIMEOUT - 32'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d       = state;
        bus.lsu_ready = 1'b0;
        bus.mem_req   = 1'b0;
        bus.lsu_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.lsu_ready = 1'b1;
                if (bus.exu_valid) state_d = (is_mem && !acc_err) ? REQ : DONE;
            end
            REQ: begin
                bus.mem_req = 1'b1;
                if (wd_hit)           state_d = DONE;
                else if (bus.mem_gnt) state_d = WAIT;
            end
            WAIT: begin
                if (wd_hit)              state_d = DONE;
                else if (bus.mem_rvalid) state_d = DONE;
            end
            DONE: begin
                bus.lsu_valid = 1'b1;
                if (bus.wbu_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q   <= 32'd0;
            dout_q  <= 32'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            we_q    <= 1'b0;
            m2r_q   <= 1'b0;
            regw_q  <= 1'b0;
            err_q   <= 1'b0;
            memrd_q <= 1'b0;
            f3_q    <= 3'd0;
            wd_cnt  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    wd_cnt <= 8'd0;
                    if (bus.exu_valid) begin
                        res_q   <= bus.exu_res;
                        m2r_q   <= bus.exu_memtoreg;
                        regw_q  <= bus.exu_regw & ~acc_err;
                        err_q   <= acc_err;
                        dout_q  <= 32'd0;
                        f3_q    <= bus.exu_funct3;
                        memrd_q <= bus.exu_memrd;
                        if (is_mem && !acc_err) begin
                            addr_q  <= bus.exu_res;
                            we_q    <= bus.exu_memwr;
                            wdata_q <= wdata_d;
                            wstrb_q <= wstrb_d;
                        end
                    end
                end
                REQ, WAIT: begin
                    wd_cnt <= wd_cnt + 8'd1;
                    if (wd_hit) begin
                        err_q  <= 1'b1;
                        regw_q <= 1'b0;
                        dout_q <= 32'd0;
                    end else if (state == WAIT && bus.mem_rvalid) begin
                        dout_q <= memrd_q ? ld_ext : 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wstrb = wstrb_q;
    assign bus.res       = res_q;
    assign bus.dataout   = dout_q;
    assign bus.memtoreg  = m2r_q;
    assign bus.regw      = regw_q;
    assign bus.lsu_err   = err_q;

endmodule
